// File: rtl/time_set_controller.sv
// time_set_controller: pushbutton front end for setting the clock.
// Synchronizes and debounces mode/up/down, steps the field-select FSM and
// produces single-cycle inc/dec strobes with hold auto-repeat plus a blink.
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned BLINK_HALF      = 12500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_mode,
  input  logic button_up,
  input  logic button_down,
  output logic clock_run,
  output logic sel_hours,
  output logic sel_minutes,
  output logic sel_seconds,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic blink
);

  localparam int unsigned MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CD = (REPEAT_PERIOD > BLINK_HALF) ? REPEAT_PERIOD : BLINK_HALF;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  // Every counter stops at (limit - 1), so $clog2 of the largest limit is enough.
  localparam int unsigned CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam int unsigned NB     = 3;   // button index: 0 mode, 1 up, 2 down

  typedef enum logic [1:0] {ST_RUN, ST_SET_H, ST_SET_M, ST_SET_S} state_t;

  state_t        state_q, state_d;
  logic [NB-1:0] raw_c, sync1_q, sync2_q, deb_q, deb_prev_q, press_c;
  logic [CW-1:0] deb_cnt_q [NB];
  // Repeat channels: 0 up, 1 down. armed = a press was seen and the hold is still valid.
  logic [1:0]    armed_q, armed_d, phase_q, phase_d, strobe_c;
  logic [CW-1:0] rep_cnt_q [2];
  logic [CW-1:0] rep_cnt_d [2];
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_d, clock_run_d, sel_hours_d, sel_minutes_d, sel_seconds_d;

  assign raw_c   = {button_down, button_up, button_mode};
  assign press_c = deb_q & ~deb_prev_q;

  // Two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_c;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: level follows the synchronized input after DEBOUNCE_CYCLES of disagreement
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= '0;
    end else begin
      deb_prev_q <= deb_q;
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] >= CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // State, repeat, blink and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      armed_q      <= '0;
      phase_q      <= '0;
      rep_cnt_q[0] <= '0;
      rep_cnt_q[1] <= '0;
      blink_cnt_q  <= '0;
      clock_run    <= 1'b1;
      sel_hours    <= 1'b0;
      sel_minutes  <= 1'b0;
      sel_seconds  <= 1'b0;
      inc_pulse    <= 1'b0;
      dec_pulse    <= 1'b0;
      blink        <= 1'b1;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      phase_q      <= phase_d;
      rep_cnt_q[0] <= rep_cnt_d[0];
      rep_cnt_q[1] <= rep_cnt_d[1];
      blink_cnt_q  <= blink_cnt_d;
      clock_run    <= clock_run_d;
      sel_hours    <= sel_hours_d;
      sel_minutes  <= sel_minutes_d;
      sel_seconds  <= sel_seconds_d;
      inc_pulse    <= strobe_c[0];
      dec_pulse    <= strobe_c[1];
      blink        <= blink_d;
    end
  end

  // Next state, strobe/repeat decisions, blink and output decode
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    phase_d      = phase_q;
    rep_cnt_d[0] = rep_cnt_q[0];
    rep_cnt_d[1] = rep_cnt_q[1];
    strobe_c     = '0;
    blink_d      = blink;
    blink_cnt_d  = blink_cnt_q;

    if (press_c[0]) begin
      unique case (state_q)
        ST_RUN:   state_d = ST_SET_H;
        ST_SET_H: state_d = ST_SET_M;
        ST_SET_M: state_d = ST_SET_S;
        default:  state_d = ST_RUN;
      endcase
    end

    for (int j = 0; j < 2; j++) begin
      if (state_q == ST_RUN || !deb_q[j+1] || deb_q[2-j]) begin
        // Idle, released, or both buttons down: nothing may repeat
        armed_d[j]   = 1'b0;
        phase_d[j]   = 1'b0;
        rep_cnt_d[j] = '0;
      end else if (press_c[0]) begin
        // A field change never coincides with a strobe; the hold timer restarts
        phase_d[j]   = 1'b0;
        rep_cnt_d[j] = '0;
      end else if (press_c[j+1]) begin
        strobe_c[j]  = 1'b1;
        armed_d[j]   = 1'b1;
        phase_d[j]   = 1'b0;
        rep_cnt_d[j] = '0;
      end else if (armed_q[j]) begin
        if (rep_cnt_q[j] >= (phase_q[j] ? CW'(REPEAT_PERIOD - 1) : CW'(REPEAT_DELAY - 1))) begin
          strobe_c[j]  = 1'b1;
          phase_d[j]   = 1'b1;
          rep_cnt_d[j] = '0;
        end else begin
          rep_cnt_d[j] = rep_cnt_q[j] + CW'(1);
        end
      end
    end

    if (state_d == ST_RUN) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (state_d != state_q) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (|strobe_c) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q >= CW'(BLINK_HALF - 1)) begin
      blink_d     = ~blink;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + CW'(1);
    end

    clock_run_d   = (state_d == ST_RUN);
    sel_hours_d   = (state_d == ST_SET_H);
    sel_minutes_d = (state_d == ST_SET_M);
    sel_seconds_d = (state_d == ST_SET_S);
  end

endmodule
